rf_write_scheduler: RTL

Sequencing front-end for the 16x16 register file's single write port. Arbitrates round-robin between two writeback requesters (req0 = ALU, req1 = memory load) and drives the register file's WriteReg/DstReg/DstData from registered outputs. Keeps a per-register pending-write scoreboard so decode can stall on source registers with outstanding writes. The register file has no internal forwarding, so this scoreboard is the only hazard protection.

---
 rtl/rf_write_scheduler_pkg.sv | 39 +++
 rtl/rf_write_scheduler_if.sv | 42 ++++
 rtl/rf_pending_counter.sv | 63 ++++++
 rtl/rf_write_scheduler.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/rf_write_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// rf_write_scheduler_pkg
//
// Shared definitions for the register-file write scheduler.
//   REG_ADDR_W / DATA_W / NUM_REGS : geometry of the 16x16 register file
//   req_id_e                       : writeback requester identity
//   rf_wr_t                        : one register-file write (WriteReg/DstReg/DstData)
//   reg_onehot()                   : register address to one-hot select vector
// ---------------------------------------------------------------------------
package rf_write_scheduler_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 16;
  localparam int NUM_REGS   = 16;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     data_t;

  // Requester identity; also the encoding of the round-robin last-grant pointer.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_e;

  // One write as presented to the register file's single write port.
  typedef struct packed {
    logic      wen;
    reg_addr_t dst;
    data_t     data;
  } rf_wr_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t r);
    logic [NUM_REGS-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rf_write_scheduler_if.sv
// ---------------------------------------------------------------------------
// rf_write_scheduler_if
//
// Writeback request bundle for the two requesters (req0 = ALU, req1 = load).
//
// Handshake: a transfer happens in a cycle where valid && ready are both high
// at the rising edge. valid never depends on ready. Once valid is raised, the
// reg/data fields stay stable until the transfer happens. ready is a
// combinational grant driven by the scheduler.
//
// Modports:
//   master : requester side  (drives valid/reg/data, observes ready)
//   slave  : scheduler side  (observes valid/reg/data, drives ready)
// ---------------------------------------------------------------------------
interface rf_write_scheduler_if;
  import rf_write_scheduler_pkg::*;

  logic      req0_valid;
  reg_addr_t req0_reg;
  data_t     req0_data;
  logic      req0_ready;

  logic      req1_valid;
  reg_addr_t req1_reg;
  data_t     req1_data;
  logic      req1_ready;

  modport master (
    output req0_valid, req0_reg, req0_data,
    input  req0_ready,
    output req1_valid, req1_reg, req1_data,
    input  req1_ready
  );

  modport slave (
    input  req0_valid, req0_reg, req0_data,
    output req0_ready,
    input  req1_valid, req1_reg, req1_data,
    output req1_ready
  );

endinterface

// File: rtl/rf_pending_counter.sv
// ---------------------------------------------------------------------------
// rf_pending_counter
//
// Pending-write counter for one register. Counts reservations not yet matched
// by an issued write.
//   clk, rst : clock, asynchronous active-high reset
//   inc_i    : reservation this cycle
//   dec_i    : a write to this register is on the write port this cycle
//   busy_o   : count is non-zero (registered)
//   ovf_o    : increment attempted at the maximum count (combinational pulse)
//
// inc and dec together cancel. Increment saturates at all-ones; decrement
// floors at zero so a write that was never reserved is harmless.
// ---------------------------------------------------------------------------
module rf_pending_counter #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic dec_i,
  output logic busy_o,
  output logic ovf_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    ovf_o   = 1'b0;
    unique case ({inc_i, dec_i})
      2'b10: begin
        if (count_q == CNT_MAX) begin
          ovf_o = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      2'b01: begin
        if (count_q != '0) begin
          count_d = count_q - 1'b1;
        end
      end
      default: begin
        count_d = count_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign busy_o = (count_q != '0);

endmodule

// File: rtl/rf_write_scheduler.sv
// ---------------------------------------------------------------------------
// rf_write_scheduler
//
// Front-end for the register file's single write port. Arbitrates
// round-robin between the ALU (req0) and load (req1) writeback requesters,
// registers the winner onto WriteReg/DstReg/DstData, and keeps a per-register
// pending-write scoreboard that decode uses to stall on source registers.
// The register file does not forward, so the scoreboard is the only hazard
// protection.
//
// Parameters:
//   ZERO_REG : 1 = register 0 is read-only (writes accepted then dropped,
//              reservations ignored)
//   CNT_W    : width of each pending-write counter
//
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   req                  : writeback request bundle (slave side)
//   rsv_valid, rsv_reg   : reserve a pending write on rsv_reg
//   chk_reg1/2           : decode source registers
//   chk_busy1/2          : source register has a pending write (comb.)
//   busy_vec             : per-register pending flag
//   rf_wen/rf_dst/rf_data: registered register-file write port
//   err                  : sticky pending-counter overflow
// ---------------------------------------------------------------------------
module rf_write_scheduler
  import rf_write_scheduler_pkg::*;
#(
  parameter bit ZERO_REG = 1'b1,
  parameter int CNT_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  rf_write_scheduler_if.slave   req,
  input  logic                  rsv_valid,
  input  reg_addr_t             rsv_reg,
  input  reg_addr_t             chk_reg1,
  input  reg_addr_t             chk_reg2,
  output logic                  chk_busy1,
  output logic                  chk_busy2,
  output logic [NUM_REGS-1:0]   busy_vec,
  output logic                  rf_wen,
  output reg_addr_t             rf_dst,
  output data_t                 rf_data,
  output logic                  err
);

  // Registers excluded from the scoreboard.
  localparam logic [NUM_REGS-1:0] ZERO_MASK = {{(NUM_REGS-1){1'b0}}, ZERO_REG};

  // -------------------------------------------------------------------------
  // Round-robin arbiter
  // -------------------------------------------------------------------------
  // last_q names the requester granted most recently. It resets to REQ_MEM so
  // the first conflict after reset goes to the ALU.
  req_id_e last_q;
  req_id_e last_d;
  logic    grant0;
  logic    grant1;

  // The output stage drains every cycle, so a lone valid is always granted.
  // Grants are held off while rst is high since nothing can be captured then.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (req.req0_valid && req.req1_valid) begin
        if (last_q == REQ_MEM) begin
          grant0 = 1'b1;
        end else begin
          grant1 = 1'b1;
        end
      end else begin
        grant0 = req.req0_valid;
        grant1 = req.req1_valid;
      end
    end
  end

  assign req.req0_ready = grant0;
  assign req.req1_ready = grant1;

  // -------------------------------------------------------------------------
  // Output stage
  // -------------------------------------------------------------------------
  rf_wr_t wr_q;
  rf_wr_t wr_d;

  always_comb begin
    last_d      = last_q;
    wr_d.wen    = 1'b0;
    wr_d.dst    = wr_q.dst;
    wr_d.data   = wr_q.data;
    if (grant0) begin
      last_d    = REQ_ALU;
      wr_d.dst  = req.req0_reg;
      wr_d.data = req.req0_data;
    end else if (grant1) begin
      last_d    = REQ_MEM;
      wr_d.dst  = req.req1_reg;
      wr_d.data = req.req1_data;
    end
    // A write to a read-only register 0 is accepted but never reaches WriteReg.
    if (grant0 || grant1) begin
      wr_d.wen = !(ZERO_REG && (wr_d.dst == '0));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= REQ_MEM;
      wr_q   <= '0;
    end else begin
      last_q <= last_d;
      wr_q   <= wr_d;
    end
  end

  assign rf_wen  = wr_q.wen;
  assign rf_dst  = wr_q.dst;
  assign rf_data = wr_q.data;

  // -------------------------------------------------------------------------
  // Pending-write scoreboard
  // -------------------------------------------------------------------------
  // The write leaving on rf_wen this cycle retires one pending count at the
  // edge where the register file captures it, so busy drops exactly when
  // the new value becomes readable.
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic [NUM_REGS-1:0] ovf_vec;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (rsv_valid) begin
      inc_vec = reg_onehot(rsv_reg) & ~ZERO_MASK;
    end
    if (wr_q.wen) begin
      dec_vec = reg_onehot(wr_q.dst) & ~ZERO_MASK;
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_cnt
    rf_pending_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc_i  (inc_vec[r]),
      .dec_i  (dec_vec[r]),
      .busy_o (busy_vec[r]),
      .ovf_o  (ovf_vec[r])
    );
  end

  // Sticky overflow: once any counter saturates, the scoreboard can no
  // longer be trusted until reset.
  logic err_q;
  logic err_d;

  always_comb begin
    err_d = err_q | (|ovf_vec);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

  // Source-register hazard lookup from registered counts.
  assign chk_busy1 = busy_vec[chk_reg1];
  assign chk_busy2 = busy_vec[chk_reg2];

  // -------------------------------------------------------------------------
  // Embedded properties
  // -------------------------------------------------------------------------
  a_one_grant : assert property (@(posedge clk) disable iff (rst)
    !(grant0 && grant1));

  a_lone_valid_granted : assert property (@(posedge clk) disable iff (rst)
    (req.req0_valid || req.req1_valid) |-> (grant0 || grant1));

endmodule
